// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: sync, polarity fix, debounce, press/release strobes.
// Define BUTTON_AUTOREPEAT_EN to build the per-channel typematic auto-repeat FSM.
module button_conditioner #(
  parameter int                 BUTTONS         = 4,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [BUTTONS-1:0] INVERT_MASK     = '0,
  parameter int                 REPEAT_DELAY    = 25_000_000,
  parameter int                 REPEAT_PERIOD   = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUTTONS-1:0] raw_signal,
  output logic [BUTTONS-1:0] level,
  output logic [BUTTONS-1:0] press_pulse,
  output logic [BUTTONS-1:0] release_pulse,
  output logic [BUTTONS-1:0] repeat_pulse,
  output logic               any_pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (BUTTONS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: all size/timing parameters must be >= 1");
  end

  logic [BUTTONS-1:0] sync0;
  logic [BUTTONS-1:0] sync1;
  logic [BUTTONS-1:0] cond;
  logic [CW-1:0]      cnt [BUTTONS];

  // Sync flops reset to the idle pin level so inverted channels do not see a phantom press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= INVERT_MASK;
      sync1 <= INVERT_MASK;
    end else begin
      sync0 <= raw_signal;
      sync1 <= sync0;
    end
  end

  assign cond = sync1 ^ INVERT_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      level         <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < BUTTONS; i++) cnt[i] <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < BUTTONS; i++) begin
        if (cond[i] != level[i]) begin
          if (cnt[i] == DEB_LAST) begin
            level[i]         <= cond[i];
            cnt[i]           <= '0;
            press_pulse[i]   <= cond[i];
            release_pulse[i] <= ~cond[i];
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign any_pressed = |level;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int TWD = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int TWP = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int TW  = (TWD > TWP) ? TWD : TWP;
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  rpt_state_t    state     [BUTTONS];
  rpt_state_t    state_nxt [BUTTONS];
  logic [TW-1:0] tmr       [BUTTONS];
  logic [TW-1:0] tmr_nxt   [BUTTONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUTTONS; i++) begin
        state[i] <= IDLE;
        tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < BUTTONS; i++) begin
        state[i] <= state_nxt[i];
        tmr[i]   <= tmr_nxt[i];
      end
    end
  end

  // Strobe is decoded from the state, gated by level so the release cycle never repeats.
  always_comb begin
    repeat_pulse = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      state_nxt[i] = state[i];
      tmr_nxt[i]   = tmr[i];
      if (!level[i]) begin
        state_nxt[i] = IDLE;
        tmr_nxt[i]   = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (press_pulse[i]) begin
              state_nxt[i] = DELAY;
              tmr_nxt[i]   = '0;
            end
          end
          DELAY: begin
            if (tmr[i] == DELAY_LAST) begin
              repeat_pulse[i] = 1'b1;
              state_nxt[i]    = RPT;
              tmr_nxt[i]      = '0;
            end else begin
              tmr_nxt[i] = tmr[i] + TW'(1);
            end
          end
          RPT: begin
            if (tmr[i] == PERIOD_LAST) begin
              repeat_pulse[i] = 1'b1;
              tmr_nxt[i]      = '0;
            end else begin
              tmr_nxt[i] = tmr[i] + TW'(1);
            end
          end
          default: begin
            state_nxt[i] = IDLE;
            tmr_nxt[i]   = '0;
          end
        endcase
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a cycle-stamped expectation queue.
// Repeat expectations are only queued when BUTTON_AUTOREPEAT_EN is defined.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_signal;
  logic [3:0] level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;
  logic       any_pressed;

  button_conditioner #(
    .BUTTONS(4),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK(4'b0100),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_signal(raw_signal),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] rp;
    logic [3:0] lv;
    string      tag;
  } exp_t;

  exp_t       sb [$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_level = 4'b0000;

  task automatic expect_at(input int dly, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] rp, input logic [3:0] lv, input string tag);
    exp_t e;
    e.cyc = cyc + dly;
    e.p   = p;
    e.r   = r;
    e.rp  = rp;
    e.lv  = lv;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    raw_signal = raw;
  endtask

  // Any cycle without a queued entry expects no strobes and the last queued level.
  task automatic checkOutput();
    exp_t       e;
    logic [3:0] xp = 4'b0000;
    logic [3:0] xr = 4'b0000;
    logic [3:0] xrp = 4'b0000;
    string      tag = "quiet";
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_cmp++;
      assert (0) else begin
        n_err++;
        $error("[TB] FAIL %s missed: observed no check at cycle %0d expected check", e.tag, e.cyc);
      end
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      xp = e.p;
      xr = e.r;
      xrp = e.rp;
      exp_level = e.lv;
      tag = e.tag;
    end
    n_cmp++;
    assert (level === exp_level) else begin
      n_err++;
      $error("[TB] FAIL %s level @%0d: observed %b expected %b", tag, cyc, level, exp_level);
    end
    n_cmp++;
    assert (press_pulse === xp) else begin
      n_err++;
      $error("[TB] FAIL %s press @%0d: observed %b expected %b", tag, cyc, press_pulse, xp);
    end
    n_cmp++;
    assert (release_pulse === xr) else begin
      n_err++;
      $error("[TB] FAIL %s release @%0d: observed %b expected %b", tag, cyc, release_pulse, xr);
    end
    n_cmp++;
    assert (repeat_pulse === xrp) else begin
      n_err++;
      $error("[TB] FAIL %s repeat @%0d: observed %b expected %b", tag, cyc, repeat_pulse, xrp);
    end
    n_cmp++;
    assert (any_pressed === (|exp_level)) else begin
      n_err++;
      $error("[TB] FAIL %s any_pressed @%0d: observed %b expected %b", tag, cyc, any_pressed, |exp_level);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
    end
  endtask

  initial begin
    // Channel 2 is active-low, so its idle pin is high through reset.
    rst = 1'b1;
    applyStimulus(4'b0100);
    step(2);
    rst = 1'b0;
    step(3);

    $display("[TB] ch0 clean press, held into auto-repeat");
    applyStimulus(4'b0101);
    expect_at(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "press0");
`ifdef BUTTON_AUTOREPEAT_EN
    expect_at(16, 4'b0000, 4'b0000, 4'b0001, 4'b0001, "rpt0_first");
    expect_at(19, 4'b0000, 4'b0000, 4'b0001, 4'b0001, "rpt0_second");
`endif
    step(20);

    $display("[TB] reset pulse while ch0 held");
    rst = 1'b1;
    expect_at(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mid_reset");
    step(1);
    rst = 1'b0;
    expect_at(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "press0_requal");
    step(8);

    $display("[TB] ch0 release with ch3 press");
    applyStimulus(4'b1100);
    expect_at(6, 4'b1000, 4'b0001, 4'b0000, 4'b1000, "rel0_press3");
    step(8);

    $display("[TB] ch0 press and ch3 release on the same edge");
    applyStimulus(4'b0101);
    expect_at(6, 4'b0001, 4'b1000, 4'b0000, 4'b0001, "press0_rel3");
    step(8);
    applyStimulus(4'b0100);
    expect_at(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000, "rel0");
    step(8);

    $display("[TB] ch1 bounce never qualifies");
    for (int t = 0; t < 10; t++) begin
      applyStimulus((t % 2 == 0) ? 4'b0110 : 4'b0100);
      step(2);
    end
    applyStimulus(4'b0100);
    step(10);

    $display("[TB] ch1 held for auto-repeat then dropped");
    applyStimulus(4'b0110);
    expect_at(6, 4'b0010, 4'b0000, 4'b0000, 4'b0010, "press1");
`ifdef BUTTON_AUTOREPEAT_EN
    expect_at(16, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "rpt1_first");
    expect_at(19, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "rpt1_second");
    expect_at(22, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "rpt1_third");
`endif
    step(18);
    applyStimulus(4'b0100);
    expect_at(6, 4'b0000, 4'b0010, 4'b0000, 4'b0000, "rel1");
    step(20);

    $display("[TB] ch2 active-low press and release");
    applyStimulus(4'b0000);
    expect_at(6, 4'b0100, 4'b0000, 4'b0000, 4'b0100, "press2_inv");
    step(8);
    applyStimulus(4'b0100);
    expect_at(6, 4'b0000, 4'b0100, 4'b0000, 4'b0000, "rel2_inv");
    step(16);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("[TB] FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
